// File: rtl/vga_sprite_compositor_pkg.sv
// Shared types and defaults for the VGA sprite compositor: timing defaults,
// the rectangle table entry and the RGB332 colour field positions.
package vga_pkg;

  localparam int RECT_COORD_W = 10;
  localparam int RECT_COLOR_W = 8;

  localparam int HBP_DEFAULT = 144;
  localparam int HFP_DEFAULT = 784;
  localparam int VBP_DEFAULT = 31;
  localparam int VFP_DEFAULT = 511;

  localparam int RED_MSB   = 7;
  localparam int RED_LSB   = 5;
  localparam int GREEN_MSB = 4;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_MSB  = 1;
  localparam int BLUE_LSB  = 0;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] min_x;
    logic [RECT_COORD_W-1:0] min_y;
    logic [RECT_COORD_W-1:0] max_x;
    logic [RECT_COORD_W-1:0] max_y;
    logic [RECT_COLOR_W-1:0] color;
    logic                    visible;
  } rect_t;

endpackage

// File: rtl/vga_sprite_compositor_rect_hit.sv
// Inclusive-bounds hit test of one rectangle against the current beam position.
// An inverted rectangle (min > max on either axis) can never hit.
module rect_hit
  import vga_pkg::*;
(
  input  rect_t                   rect,
  input  logic [RECT_COORD_W-1:0] hc,
  input  logic [RECT_COORD_W-1:0] vc,
  output logic                    hit
);

  assign hit = rect.visible &&
               (rect.min_x <= hc) && (hc <= rect.max_x) &&
               (rect.min_y <= vc) && (vc <= rect.max_y);

endmodule

// File: rtl/vga_sprite_compositor.sv
// Two-stage priority compositor with a double-buffered rectangle table that is
// published atomically at vertical blank, plus per-frame player collision.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int NUM_RECTS = 10,
  parameter int COORD_W   = RECT_COORD_W,
  parameter int COLOR_W   = RECT_COLOR_W,
  parameter int HBP       = HBP_DEFAULT,
  parameter int HFP       = HFP_DEFAULT,
  parameter int VBP       = VBP_DEFAULT,
  parameter int VFP       = VFP_DEFAULT,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  localparam int IDX_W    = $clog2(NUM_RECTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  logic               wr_en,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_min_x,
  input  logic [COORD_W-1:0] wr_min_y,
  input  logic [COORD_W-1:0] wr_max_x,
  input  logic [COORD_W-1:0] wr_max_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_visible,
  input  logic               commit,
  output logic               commit_done,
  output logic [COLOR_W-1:0] rgb,
  output logic               pix_active,
  output logic               collision
);

  rect_t shadow_q [NUM_RECTS];
  rect_t shadow_d [NUM_RECTS];
  rect_t disp_q   [NUM_RECTS];
  rect_t disp_d   [NUM_RECTS];

  logic [NUM_RECTS-1:0] hit;
  logic [NUM_RECTS-1:0] hit_q, hit_d;
  logic                 act1_q, act1_d;
  logic                 coll1_q, coll1_d;
  logic [COLOR_W-1:0]   rgb_q, rgb_d;
  logic                 act2_q, act2_d;
  logic                 pending_q, pending_d;
  logic                 sticky_q, sticky_d;
  logic                 collision_q, collision_d;

  logic swap_pt;
  logic do_copy;
  logic active_now;

  for (genvar k = 0; k < NUM_RECTS; k++) begin : g_hit
    rect_hit u_rect_hit (
      .rect (disp_q[k]),
      .hc   (hc),
      .vc   (vc),
      .hit  (hit[k])
    );
  end

  assign swap_pt    = (vc == COORD_W'(VFP)) && (hc == '0);
  assign do_copy    = swap_pt && (pending_q || commit);
  assign active_now = (hc >= COORD_W'(HBP)) && (hc < COORD_W'(HFP)) &&
                      (vc >= COORD_W'(VBP)) && (vc < COORD_W'(VFP));

  // Writes are refused only while the table copy happens, keeping it atomic.
  assign wr_ready    = !do_copy;
  assign commit_done = do_copy;

  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    if (wr_en && wr_ready && (int'(wr_idx) < NUM_RECTS)) begin
      shadow_d[wr_idx] = '{min_x:   wr_min_x,
                           min_y:   wr_min_y,
                           max_x:   wr_max_x,
                           max_y:   wr_max_y,
                           color:   wr_color,
                           visible: wr_visible};
    end
    if (do_copy) begin
      disp_d = shadow_q;
    end
    pending_d = do_copy ? 1'b0 : (pending_q || commit);
  end

  always_comb begin
    hit_d   = hit;
    act1_d  = active_now;
    coll1_d = active_now && hit[0] && (|hit[NUM_RECTS-1:1]);
    act2_d  = act1_q;
    rgb_d   = '0;
    // Walk from the lowest priority up so the lowest hit index is written last.
    if (act1_q) begin
      rgb_d = BG_COLOR;
      for (int k = NUM_RECTS - 1; k >= 0; k--) begin
        if (hit_q[k]) begin
          rgb_d = disp_q[k].color;
        end
      end
    end
  end

  always_comb begin
    sticky_d    = sticky_q || coll1_q;
    collision_d = collision_q;
    if (swap_pt) begin
      collision_d = sticky_q || coll1_q;
      sticky_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_RECTS; k++) begin
        shadow_q[k] <= '0;
        disp_q[k]   <= '0;
      end
      hit_q       <= '0;
      act1_q      <= 1'b0;
      coll1_q     <= 1'b0;
      rgb_q       <= '0;
      act2_q      <= 1'b0;
      pending_q   <= 1'b0;
      sticky_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      hit_q       <= hit_d;
      act1_q      <= act1_d;
      coll1_q     <= coll1_d;
      rgb_q       <= rgb_d;
      act2_q      <= act2_d;
      pending_q   <= pending_d;
      sticky_q    <= sticky_d;
      collision_q <= collision_d;
    end
  end

  assign rgb        = rgb_q;
  assign pix_active = act2_q;
  assign collision  = collision_q;

endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Next-generation pixel compositor for the VGA path. Replaces the combinational, OR-blended rectangle painter.
- Holds NUM_RECTS rectangles in an internal double-buffered table. The game logic writes the table through a ready/valid-style port and commits it atomically at vertical blank.
- Produces a registered, priority-resolved pixel colour 2 cycles after hc/vc.
- Also reports per-frame collision between rectangle 0 (the player) and any other visible rectangle.

Parameters:
- NUM_RECTS, 10, number of rectangle slots; index 0 has highest priority and is the player.
- COORD_W, 10, width of hc/vc and of all rectangle coordinates.
- COLOR_W, 8, pixel colour width; 8 maps to R[7:5] G[4:2] B[1:0].
- HBP, 144, first active horizontal count.
- HFP, 784, first horizontal count past active.
- VBP, 31, first active vertical count.
- VFP, 511, first vertical count past active.
- BG_COLOR, 0, colour of active pixels not covered by any rectangle.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hc  in  COORD_W  horizontal counter from the sync generator.
- vc  in  COORD_W  vertical counter from the sync generator.
- wr_en  in  1  write request to the shadow table.
- wr_ready  out  1  write accepted when wr_en && wr_ready.
- wr_idx  in  $clog2(NUM_RECTS)  slot index.
- wr_min_x, wr_min_y, wr_max_x, wr_max_y  in  COORD_W each  inclusive bounds.
- wr_color  in  COLOR_W  slot colour.
- wr_visible  in  1  slot enable.
- commit  in  1  one-cycle request to publish the shadow table at the next vblank.
- commit_done  out  1  one-cycle pulse in the swap cycle.
- rgb  out  COLOR_W  composited pixel.
- pix_active  out  1  rgb corresponds to the active region (aligned with rgb).
- collision  out  1  previous frame saw the player overlap another rect.

Behaviour:
- Reset: all shadow and active slots are cleared (visible=0, bounds 0, colour 0). Outputs reset to rgb=0, pix_active=0, commit_done=0, collision=0, wr_ready=1. The commit-pending flag and the sticky collision flag clear. Reset mid-frame takes effect immediately and asynchronously; release is used synchronously.
- Active region: HBP<=hc<HFP and VBP<=vc<VFP.
- Hit rule, per slot k: visible and min_x<=hc<=max_x and min_y<=vc<=max_y, unsigned compare. min>max on either axis never hits.
- Pipeline stage 1 registers:
  - the NUM_RECTS hit vector;
  - the active flag;
  - coll_now = hit[0] && |hit[NUM_RECTS-1:1], gated by active.
- Pipeline stage 2 resolves priority (lowest hit index wins) and registers rgb and pix_active.
- Output rules, applied at stage 2:
  - inactive pixel gives rgb=0;
  - active with no hit gives rgb=BG_COLOR.
- Latency: exactly 2 clocks from hc/vc to rgb/pix_active. There is no OR-blending of colours.
- Writes: when wr_en && wr_ready and wr_idx<NUM_RECTS, the shadow slot wr_idx takes all fields at the clock edge. If wr_idx>=NUM_RECTS the write is accepted but dropped. The active table is never written directly.
- Commit:
  - commit=1 sets pending.
  - The swap point is the cycle with vc==VFP && hc==0.
  - If pending, or commit is asserted in that same cycle, the whole shadow table is copied to the active table at that edge. In that case pending clears and commit_done pulses for 1 cycle.
  - With no pending request, the swap point does nothing.
  - Repeated commits before the swap collapse into a single swap.
- wr_ready is 0 only in a swap cycle where a copy occurs. This guarantees the copy is atomic. A write presented then is held off by one cycle.
- The shadow table is retained after a swap; a partial update plus commit publishes the unchanged slots as well.
- Collision: the sticky flag ORs in coll_now every cycle. At every swap point, whether or not a copy occurs:
  - collision <= sticky | coll_now;
  - the sticky flag clears.
  - collision holds that value for one full frame.

Decomposition:
- Package vga_pkg holds:
  - HBP/HFP/VBP/VFP defaults;
  - typedef rect_t {min_x, min_y, max_x, max_y, color, visible};
  - the colour slice constants for R/G/B.
- One sub-module, rect_hit: combinational inclusive-bounds test of one rect_t against hc/vc. It is instantiated NUM_RECTS times via generate.
- Priority encode, bank swap and collision logic stay in the top module.

Test Plan:
- Reset, then sweep one full frame → rgb=0 everywhere and pix_active=1 only inside 144..783 × 31..510; wr_ready=1 and collision=0 throughout.
- Write slot 0 = (200,100)-(220,120), colour 0xE0, visible; commit; run past vc=511,hc=0 → commit_done pulses once; at hc=200,vc=100, rgb=0xE0 two cycles later; at hc=221, rgb=BG_COLOR.
- Write slot 3 = (210,110)-(300,200), colour 0x1C; commit → at (215,115) rgb=0xE0 (slot 0 wins); at (250,150) rgb=0x1C. The previous frame had no overlap, so collision=0. After the next swap, collision=1.
- Write slot 2 with colour 0x03 but no commit → the display is unchanged for 3 frames. Then commit exactly in the swap cycle → the swap happens in that cycle and wr_ready=0 for that one cycle only.
- Set hc=100 (blanking) inside a visible rect's y range → rgb=0 and pix_active=0. Write with wr_idx=12 → no slot changes.
- Assert rst_n=0 mid-frame after loading slots → rgb=0 asynchronously. After release, the display is all background until new writes and a commit.
